mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mem_arbiter_if                                             |
// | Brief   : Bus bundle for the two-requester memory arbiter: fetch     |
// |           port, data port and downstream memory port.               |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface mem_arbiter_if;
  // Fetch port
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_err;
  // Data port
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_ack;
  logic [31:0] d_rdata;
  logic        d_err;
  // Memory port
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  // Arbiter side
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
    output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  // Requesters and memory side
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wstrb, mem_ack, mem_rdata,
    input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
           mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mem_arbiter                                                |
// | Brief   : Two-port (fetch/data) to single memory port arbiter with   |
// |           data priority, fetch anti-starvation and BUSY timeout.     |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mem_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus
);

  localparam logic [2:0] c_starve_max = 3'(STARVE_MAX);
  // Last BUSY cycle count value before the transaction is abandoned
  localparam logic [7:0] c_tmo_last   = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_grant_data;
  logic        w_grant_fetch;
  logic        w_timeout;

  logic        r_gnt_data;   // 1: data port owns the current transaction
  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic [31:0] r_if_rdata;
  logic [31:0] r_d_rdata;
  logic        r_err;
  logic [2:0]  r_starve_cnt;
  logic [7:0]  r_tmo_cnt;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Arbitration decision, completion/timeout detection and next state
  always_comb begin
    w_state_nxt   = r_state;
    w_grant_data  = 1'b0;
    w_grant_fetch = 1'b0;
    w_timeout     = 1'b0;
    case (r_state)
      S_IDLE: begin
        // Data wins unless fetch has waited through STARVE_MAX data grants
        if (bus.d_req && !(bus.if_req && (r_starve_cnt == c_starve_max))) begin
          w_grant_data = 1'b1;
          w_state_nxt  = S_BUSY;
        end else if (bus.if_req) begin
          w_grant_fetch = 1'b1;
          w_state_nxt   = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.mem_ack) begin
          w_state_nxt = S_RESP;
        end else if (r_tmo_cnt == c_tmo_last) begin
          w_timeout   = 1'b1;
          w_state_nxt = S_RESP;
        end
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request capture, response capture, starvation and timeout counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_gnt_data   <= 1'b0;
      r_mem_req    <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= 32'h0;
      r_mem_wdata  <= 32'h0;
      r_mem_wstrb  <= 4'h0;
      r_if_rdata   <= 32'h0;
      r_d_rdata    <= 32'h0;
      r_err        <= 1'b0;
      r_starve_cnt <= 3'd0;
      r_tmo_cnt    <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_data) begin
            r_gnt_data  <= 1'b1;
            r_mem_req   <= 1'b1;
            r_mem_we    <= bus.d_we;
            r_mem_addr  <= bus.d_addr;
            r_mem_wdata <= bus.d_wdata;
            r_mem_wstrb <= bus.d_wstrb;
            r_tmo_cnt   <= 8'd0;
            if (bus.if_req && (r_starve_cnt != c_starve_max))
              r_starve_cnt <= r_starve_cnt + 3'd1;
          end else if (w_grant_fetch) begin
            r_gnt_data   <= 1'b0;
            r_mem_req    <= 1'b1;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= bus.if_addr;
            r_mem_wdata  <= 32'h0;
            r_mem_wstrb  <= 4'h0;
            r_tmo_cnt    <= 8'd0;
            r_starve_cnt <= 3'd0;
          end
        end
        S_BUSY: begin
          if (bus.mem_ack) begin
            r_mem_req <= 1'b0;
            r_err     <= 1'b0;
            if (r_gnt_data) r_d_rdata  <= bus.mem_rdata;
            else            r_if_rdata <= bus.mem_rdata;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 8'd1;
            if (w_timeout) begin
              r_mem_req <= 1'b0;
              r_err     <= 1'b1;
              if (r_gnt_data) r_d_rdata  <= 32'h0;
              else            r_if_rdata <= 32'h0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Acks and error flags exist only in RESP, for the granted port
  assign bus.if_ack    = (r_state == S_RESP) && !r_gnt_data;
  assign bus.d_ack     = (r_state == S_RESP) &&  r_gnt_data;
  assign bus.if_err    = bus.if_ack && r_err;
  assign bus.d_err     = bus.d_ack  && r_err;
  assign bus.if_rdata  = r_if_rdata;
  assign bus.d_rdata   = r_d_rdata;
  assign bus.mem_req   = r_mem_req;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_wstrb = r_mem_wstrb;

endmodule
`default_nettype wire
